// File: rtl/udp_audio_unpacker.sv
// Receive-side audio stage: assembles 16-bit PCM samples from UDP payload bytes
// into a sample FIFO and plays them out to the codec, with prefill/underrun handling.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_PREFILL | muted; wav_rden returns 0 until fifo_level reaches PREFILL
// S_PLAY    | each wav_rden pops one sample; empty FIFO on a strobe -> underrun
module udp_audio_unpacker #(
    parameter int FIFO_DEPTH    = 1024,
    parameter int PREFILL       = 256,
    parameter bit LITTLE_ENDIAN = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          udp_rec_data_valid,
    input  logic [7:0]                    udp_rec_rdata,
    input  logic [15:0]                   udp_rec_data_length,
    input  logic                          wav_rden,
    output logic [15:0]                   wav_out_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          playing,
    output logic [15:0]                   underrun_cnt,
    output logic [15:0]                   overflow_cnt
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_L   = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0] PREFILL_L = (AW+1)'(PREFILL);

    typedef enum logic {S_PREFILL, S_PLAY} state_t;
    state_t state;

    logic        valid_d;
    logic [15:0] limit;
    logic [15:0] byte_cnt;
    logic        phase;
    logic [7:0]  first_byte;
    logic        push_pend;
    logic [15:0] push_data;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [15:0]   mem [FIFO_DEPTH];

    logic        pkt_start;
    logic [15:0] len_payload;
    logic [15:0] cur_limit;
    logic [15:0] cur_idx;
    logic        cur_phase;
    logic        byte_ok;
    logic        full;
    logic        empty;
    logic        pop;
    logic        push_ok;
    logic        drop;

    always_comb begin
        pkt_start   = udp_rec_data_valid && !valid_d;
        len_payload = (udp_rec_data_length < 16'd8) ? 16'd0 : udp_rec_data_length - 16'd8;
        cur_limit   = pkt_start ? len_payload : limit;
        cur_idx     = pkt_start ? 16'd0 : byte_cnt;
        cur_phase   = pkt_start ? 1'b0 : phase;
        byte_ok     = udp_rec_data_valid && (cur_idx < cur_limit);
        full        = (fifo_level == DEPTH_L);
        empty       = (fifo_level == '0);
        pop         = (state == S_PLAY) && wav_rden && !empty;
        push_ok     = push_pend && (!full || pop);
        drop        = push_pend && full && !pop;
    end

    // valid_d resets high so a packet cut by reset is ignored until valid falls and rises again
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_d    <= 1'b1;
            limit      <= '0;
            byte_cnt   <= '0;
            phase      <= 1'b0;
            first_byte <= '0;
            push_pend  <= 1'b0;
            push_data  <= '0;
        end else begin
            valid_d   <= udp_rec_data_valid;
            push_pend <= 1'b0;
            if (pkt_start)
                limit <= len_payload;
            if (udp_rec_data_valid) begin
                byte_cnt <= (cur_idx == 16'hFFFF) ? cur_idx : cur_idx + 16'd1;
                phase    <= byte_ok ? ~cur_phase : cur_phase;
            end else begin
                phase <= 1'b0;
            end
            if (byte_ok) begin
                if (!cur_phase) begin
                    first_byte <= udp_rec_rdata;
                end else begin
                    push_pend <= 1'b1;
                    push_data <= LITTLE_ENDIAN ? {udp_rec_rdata, first_byte}
                                               : {first_byte, udp_rec_rdata};
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_level   <= '0;
            state        <= S_PREFILL;
            playing      <= 1'b0;
            wav_out_data <= '0;
            underrun_cnt <= '0;
            overflow_cnt <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase
            if (drop && overflow_cnt != 16'hFFFF)
                overflow_cnt <= overflow_cnt + 16'd1;

            case (state)
                S_PREFILL: begin
                    if (wav_rden)
                        wav_out_data <= '0;
                    if (fifo_level >= PREFILL_L) begin
                        state   <= S_PLAY;
                        playing <= 1'b1;
                    end
                end
                S_PLAY: begin
                    if (wav_rden) begin
                        if (empty) begin
                            wav_out_data <= '0;
                            state        <= S_PREFILL;
                            playing      <= 1'b0;
                            if (underrun_cnt != 16'hFFFF)
                                underrun_cnt <= underrun_cnt + 16'd1;
                        end else begin
                            wav_out_data <= mem[rd_ptr];
                        end
                    end
                end
                default: begin
                    state   <= S_PREFILL;
                    playing <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_udp_audio_unpacker.sv
// Directed bench for udp_audio_unpacker: framing, byte order, prefill/underrun,
// overflow and asynchronous reset behaviour.
module tb_udp_audio_unpacker;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid = 1'b0;
    logic [7:0]  data = 8'h00;
    logic [15:0] len = 16'd0;
    logic        rden = 1'b0;
    logic        sel2 = 1'b0;

    logic [15:0] wav1, wav2;
    logic [10:0] level1;
    logic [3:0]  level2;
    logic        play1, play2;
    logic [15:0] und1, und2, ovf1, ovf2;

    logic [7:0] pkt[$];
    int nvec = 0;
    int nmis = 0;

    always #5 clk = ~clk;

    udp_audio_unpacker #(.FIFO_DEPTH(1024), .PREFILL(4), .LITTLE_ENDIAN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .udp_rec_data_valid(valid && !sel2), .udp_rec_rdata(data),
        .udp_rec_data_length(len), .wav_rden(rden && !sel2),
        .wav_out_data(wav1), .fifo_level(level1), .playing(play1),
        .underrun_cnt(und1), .overflow_cnt(ovf1));

    udp_audio_unpacker #(.FIFO_DEPTH(8), .PREFILL(1), .LITTLE_ENDIAN(1'b0)) dut_be (
        .clk(clk), .rst_n(rst_n),
        .udp_rec_data_valid(valid && sel2), .udp_rec_rdata(data),
        .udp_rec_data_length(len), .wav_rden(rden && sel2),
        .wav_out_data(wav2), .fifo_level(level2), .playing(play2),
        .underrun_cnt(und2), .overflow_cnt(ovf2));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send_pkt(input logic [15:0] plen);
        len = plen;
        for (int i = 0; i < pkt.size(); i++) begin
            @(negedge clk);
            valid = 1'b1;
            data  = pkt[i];
        end
        @(negedge clk);
        valid = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic strobe();
        @(negedge clk);
        rden = 1'b1;
        @(negedge clk);
        rden = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_wav", wav1, 0);
        chk("rst_level", level1, 0);
        chk("rst_playing", play1, 0);
        chk("rst_underrun", und1, 0);
        chk("rst_overflow", ovf1, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // basic little-endian packet reaching prefill
        pkt = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        send_pkt(16'd16);
        chk("pkt1_level", level1, 4);
        chk("pkt1_playing", play1, 1);
        strobe(); chk("pop0", wav1, 16'h0201);
        strobe(); chk("pop1", wav1, 16'h0403);
        strobe(); chk("pop2", wav1, 16'h0605);
        strobe(); chk("pop3", wav1, 16'h0807);
        chk("drained_level", level1, 0);

        // one sample then underrun
        pkt = {8'h34, 8'h12};
        send_pkt(16'd10);
        chk("one_level", level1, 1);
        strobe(); chk("last_sample", wav1, 16'h1234);
        strobe(); chk("underrun_wav", wav1, 0);
        chk("underrun_cnt", und1, 1);
        @(negedge clk);
        chk("underrun_playing", play1, 0);

        // length 8+5 with 7 bytes streamed: odd byte and overrun bytes dropped
        pkt = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
        send_pkt(16'd13);
        chk("short_level", level1, 2);
        chk("short_playing", play1, 0);
        strobe(); chk("prefill_wav", wav1, 0);
        chk("prefill_nopop", level1, 2);
        pkt = {8'h01, 8'hA0, 8'h02, 8'hB0};
        send_pkt(16'd12);
        chk("resume_level", level1, 4);
        chk("resume_playing", play1, 1);
        strobe(); chk("short_s0", wav1, 16'h2211);
        strobe(); chk("short_s1", wav1, 16'h4433);
        strobe(); chk("short_s2", wav1, 16'hA001);
        strobe(); chk("short_s3", wav1, 16'hB002);

        // fill to depth, then overflow
        pkt = {};
        for (int k = 0; k < 1024; k++) begin
            pkt.push_back(8'(k));
            pkt.push_back(8'(k >> 8));
        end
        send_pkt(16'd2056);
        chk("full_level", level1, 1024);
        pkt = {8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5, 8'hC6};
        send_pkt(16'd14);
        chk("ovf_cnt", ovf1, 3);
        chk("ovf_level", level1, 1024);
        for (int k = 0; k < 3; k++) begin
            len = 16'd10;
            @(negedge clk); valid = 1'b1; data = 8'h55;
            @(negedge clk); data = 8'h66;
            @(negedge clk); valid = 1'b0; rden = 1'b1;
            @(negedge clk); rden = 1'b0;
            chk("full_pushpop_wav", wav1, k);
            repeat (2) @(negedge clk);
            chk("full_pushpop_level", level1, 1024);
            chk("full_pushpop_ovf", ovf1, 3);
        end

        // asynchronous reset in mid-packet and mid-playback
        len = 16'd20;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); valid = 1'b1; data = 8'hE0 + 8'(i);
        end
        #2 rst_n = 1'b0;
        #1;
        chk("arst_wav", wav1, 0);
        chk("arst_level", level1, 0);
        chk("arst_playing", play1, 0);
        chk("arst_underrun", und1, 0);
        chk("arst_overflow", ovf1, 0);
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); data = 8'hF0 + 8'(i);
        end
        @(negedge clk); valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("tail_ignored", level1, 0);
        pkt = {8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF, 8'h11, 8'h22};
        send_pkt(16'd16);
        chk("clean_level", level1, 4);
        strobe(); chk("clean_phase", wav1, 16'hBBAA);

        // big-endian instance
        sel2 = 1'b1;
        pkt = {8'hAB, 8'hCD};
        send_pkt(16'd10);
        chk("be_level", level2, 1);
        chk("be_playing", play2, 1);
        strobe(); chk("be_sample", wav2, 16'hABCD);
        chk("be_level_after", level2, 0);
        sel2 = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
